cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Control unit for the 8-bit bus CPU.
- Runs a one-hot T-state ring counter and decodes the instruction-register opcode into the control word for every datapath block.
- Sits directly upstream of the ALU. Drives its `sel` and `en` inputs, plus the loads/enables of register A, register B, PC, MAR, RAM, IR and the output register.

Parameters:
- OPW, 4, opcode width (upper nibble of the instruction word).
- NT, 7, number of T-states in a full machine cycle (T1..T7).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- run  in  1  1 = advance T-state each clock; 0 = stall.
- ir_opcode  in  OPW  opcode from instruction register; valid from T4.
- tstate  out  NT  one-hot current T-state (bit0 = T1).
- pc_out  out  1  PC drives bus.
- pc_inc  out  1  PC increments at end of cycle.
- mar_load  out  1  MAR loads from bus.
- ram_out  out  1  RAM drives bus.
- ir_load  out  1  IR loads from bus.
- ir_out  out  1  IR address nibble drives bus.
- a_load  out  1  register A loads from bus.
- a_out  out  1  register A drives bus.
- b_load  out  1  register B loads from bus.
- alu_sel  out  2  ALU operation (00 ADD, 01 SUB, 10 MLT, 11 DIV).
- alu_en  out  1  ALU result register drives bus.
- out_load  out  1  output register loads from bus.
- halted  out  1  sequencer stopped by HLT.

Behaviour:
- Reset (clr high, asynchronous):
  - tstate = 7'b0000001, halted = 0, alu_sel = 00.
  - Control outputs are the T1 decode: pc_out = 1, mar_load = 1, all others 0.
- State:
  - One-hot ring T1->T2->...->T7->T1.
  - Advances only on a clock edge with run = 1 and halted = 0.
- Control outputs are combinational decode of (tstate, latched opcode). No output is registered except alu_sel and halted.
- Opcode latch: at the rising edge ending T3 (IR loads there), the internal opcode register is not yet valid. ir_opcode is sampled at the edge leaving T4 and held until the next T4. T4 decode uses ir_opcode directly.
- Fetch, all instructions:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute:
  - LDA (0x0): T4 ir_out, mar_load. T5 ram_out, a_load. T6, T7 idle.
  - ADD/SUB/MUL/DIV (0x1/0x2/0x3/0x4): T4 ir_out, mar_load. T5 ram_out, b_load. T6 idle (ALU latches A op B at end of T6). T7 alu_en, a_load.
  - OUT (0xE): T4 a_out, out_load. T5..T7 idle.
  - HLT (0xF): T4 decode sets halted at the end of T4. From then on tstate frozen at T5 and all controls 0 until clr.
  - Any other opcode: NOP, T4..T7 idle.
- alu_sel for ALU opcodes:
  - Registered: loaded with (opcode-1) at the edge ending T4, held until the next ALU instruction.
  - Must be stable through T5..T7 so the ALU's clocked result register sees the correct sel at the T6 edge.
  - Non-ALU instructions leave alu_sel unchanged.
- Stall (run = 0):
  - tstate, alu_sel and halted hold.
  - All control outputs except alu_sel are forced to 0, so no bus drive and no loads.
  - Resuming continues from the held T-state.
- Bus safety: at most one of pc_out, ram_out, ir_out, a_out, alu_en is high in any state. This is a one-hot invariant.
- clr mid-instruction: immediate return to T1; a partially executed instruction is abandoned.

Optional Feature:
- Macro: SEQ_EARLY_END_EN.
- Defined: after the last non-idle execute state the ring returns to T1.
  - LDA = 5 states.
  - ALU ops = 7 states.
  - OUT and NOP = 4 states.
  - HLT unchanged.
- Undefined: every instruction takes exactly NT = 7 states.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_OUT, OP_HLT).
  - ALU sel constants (ALU_ADD = 00, ALU_SUB = 01, ALU_MLT = 10, ALU_DIV = 11).
  - One-hot T-state constants T1..T7.
- Sub-module ring_counter: holds the one-hot T-state with clr, run, halt and a restart input (restart is used by SEQ_EARLY_END_EN).

Test Plan:
- Reset: assert clr mid-T5 -> tstate = 0000001 immediately; pc_out = mar_load = 1, all other controls 0, alu_sel = 00.
- ADD fetch/execute: run = 1, ir_opcode = 0x1 from T4:
  - T5 ram_out + b_load.
  - T7 alu_en + a_load.
  - alu_sel = 00 from T5 to T7.
  - Check: no two bus drivers are ever high together.
- DIV then OUT: opcode 0x4 then 0xE -> alu_sel = 11 through the DIV T5..T7; alu_sel stays 11 during OUT; out_load at OUT T4.
- HLT: opcode 0xF -> halted = 1 after the T4 edge; tstate frozen; 20 further clocks with all controls 0; clr recovers to T1.
- Stall: run = 0 during T3 for 3 clocks -> tstate holds T3 with ram_out = ir_load = 0; run = 1 -> ram_out and ir_load reassert, then proceed to T4.
- SEQ_EARLY_END_EN: LDA then NOP -> next T1 follows T5 (5 clocks) and T4 (4 clocks) respectively. Without the macro, both take 7 clocks.

Source files
------------

// File: rtl/cpu_control_sequencer_pkg.sv
// cpu_pkg: shared constants for the 8-bit bus CPU control unit.
//   - opcode constants (upper nibble of the instruction word)
//   - ALU operation select encoding
//   - one-hot T-state constants T1..T7
//   - control word struct and small decode helpers
package cpu_pkg;

    localparam int OPW_DEF = 4;
    localparam int NT_DEF  = 7;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MLT = 2'b10,
        ALU_DIV = 2'b11
    } alu_sel_e;

    localparam logic [6:0] T1 = 7'b0000001;
    localparam logic [6:0] T2 = 7'b0000010;
    localparam logic [6:0] T3 = 7'b0000100;
    localparam logic [6:0] T4 = 7'b0001000;
    localparam logic [6:0] T5 = 7'b0010000;
    localparam logic [6:0] T6 = 7'b0100000;
    localparam logic [6:0] T7 = 7'b1000000;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic mar_load;
        logic ram_out;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_en;
        logic out_load;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Control bus between the sequencer and the datapath.
//   master: sequencer side (takes run/ir_opcode, drives T-state and controls)
//   slave : datapath side (drives run/ir_opcode, consumes controls)
interface cpu_control_sequencer_if #(
    parameter int OPW = 4,
    parameter int NT  = 7
);
    logic           run;
    logic [OPW-1:0] ir_opcode;
    logic [NT-1:0]  tstate;
    logic           pc_out;
    logic           pc_inc;
    logic           mar_load;
    logic           ram_out;
    logic           ir_load;
    logic           ir_out;
    logic           a_load;
    logic           a_out;
    logic           b_load;
    logic [1:0]     alu_sel;
    logic           alu_en;
    logic           out_load;
    logic           halted;

    modport master (
        input  run, ir_opcode,
        output tstate, pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_sel, alu_en, out_load, halted
    );

    modport slave (
        output run, ir_opcode,
        input  tstate, pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_sel, alu_en, out_load, halted
    );
endinterface

// File: rtl/cpu_control_sequencer_ring_counter.sv
// ring_counter: one-hot T-state ring (bit0 = T1).
//   clk, clr (async, active-high) - clock / reset to T1
//   run      - advance enable
//   halt     - freeze ring while set
//   restart  - jump back to T1 instead of rotating on the next advance
//   tstate   - one-hot current T-state
module ring_counter #(
    parameter int NT = 7
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          run,
    input  logic          halt,
    input  logic          restart,
    output logic [NT-1:0] tstate
);
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            tstate <= NT'(1);
        else if (run && !halt)
            tstate <= restart ? NT'(1) : {tstate[NT-2:0], tstate[NT-1]};
    end
endmodule

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: T-state sequencer and control-word decoder for the
// 8-bit bus CPU.
//   clk  - system clock
//   clr  - asynchronous active-high reset (back to T1, halted cleared)
//   bus  - master side of cpu_control_sequencer_if: run, ir_opcode in;
//          tstate, bus drive/load strobes, alu_sel, alu_en, halted out
// Optional: define SEQ_EARLY_END_EN to restart the ring at T1 right after
// the last non-idle execute state (LDA 5, ALU 7, OUT/NOP 4 states).
module cpu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW = 4,
    parameter int NT  = 7
) (
    input  logic                    clk,
    input  logic                    clr,
    cpu_control_sequencer_if.master bus
);
    logic [NT-1:0]  tstate;
    logic [OPW-1:0] op_q, op_d, op_eff;
    logic [1:0]     sel_q, sel_d;
    logic           halt_q, halt_d;
    logic           advance, restart;
    ctrl_t          ctrl;

    assign advance = bus.run && !halt_q;
    // The latched opcode is only valid after T4, so T4 decodes the IR directly.
    assign op_eff  = tstate[3] ? bus.ir_opcode : op_q;

    ring_counter #(.NT(NT)) u_ring (
        .clk     (clk),
        .clr     (clr),
        .run     (bus.run),
        .halt    (halt_q),
        .restart (restart),
        .tstate  (tstate)
    );

    // State register: opcode latch, ALU select, halt flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q   <= '0;
            sel_q  <= ALU_ADD;
            halt_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            sel_q  <= sel_d;
            halt_q <= halt_d;
        end
    end

    // Next-state: everything is captured at the edge leaving T4.
    always_comb begin
        op_d    = op_q;
        sel_d   = sel_q;
        halt_d  = halt_q;
        restart = 1'b0;
        if (advance && tstate[3]) begin
            op_d = bus.ir_opcode;
            if (is_alu_op(bus.ir_opcode))
                sel_d = 2'(bus.ir_opcode - 1'b1);
            if (bus.ir_opcode == OP_HLT)
                halt_d = 1'b1;
        end
`ifdef SEQ_EARLY_END_EN
        // ALU ops already end at T7; HLT must still step into T5 and freeze.
        if (tstate[3] && op_eff != OP_LDA && !is_alu_op(op_eff) && op_eff != OP_HLT)
            restart = 1'b1;
        if (tstate[4] && op_eff == OP_LDA)
            restart = 1'b1;
`endif
    end

    // Output decode; stalled or halted means no bus drive and no loads.
    always_comb begin
        ctrl = '0;
        if (advance) begin
            if (tstate[0]) begin
                ctrl.pc_out   = 1'b1;
                ctrl.mar_load = 1'b1;
            end
            if (tstate[1])
                ctrl.pc_inc = 1'b1;
            if (tstate[2]) begin
                ctrl.ram_out = 1'b1;
                ctrl.ir_load = 1'b1;
            end
            if (tstate[3]) begin
                if (op_eff == OP_LDA || is_alu_op(op_eff)) begin
                    ctrl.ir_out   = 1'b1;
                    ctrl.mar_load = 1'b1;
                end else if (op_eff == OP_OUT) begin
                    ctrl.a_out    = 1'b1;
                    ctrl.out_load = 1'b1;
                end
            end
            if (tstate[4]) begin
                if (op_eff == OP_LDA) begin
                    ctrl.ram_out = 1'b1;
                    ctrl.a_load  = 1'b1;
                end else if (is_alu_op(op_eff)) begin
                    ctrl.ram_out = 1'b1;
                    ctrl.b_load  = 1'b1;
                end
            end
            if (tstate[6] && is_alu_op(op_eff)) begin
                ctrl.alu_en = 1'b1;
                ctrl.a_load = 1'b1;
            end
        end
    end

    assign bus.tstate   = tstate;
    assign bus.pc_out   = ctrl.pc_out;
    assign bus.pc_inc   = ctrl.pc_inc;
    assign bus.mar_load = ctrl.mar_load;
    assign bus.ram_out  = ctrl.ram_out;
    assign bus.ir_load  = ctrl.ir_load;
    assign bus.ir_out   = ctrl.ir_out;
    assign bus.a_load   = ctrl.a_load;
    assign bus.a_out    = ctrl.a_out;
    assign bus.b_load   = ctrl.b_load;
    assign bus.alu_en   = ctrl.alu_en;
    assign bus.out_load = ctrl.out_load;
    assign bus.alu_sel  = sel_q;
    assign bus.halted   = halt_q;
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: instruction-level model
// (T-state number, latched opcode, alu_sel, halt) compared every cycle, plus
// literal spot checks at the interesting points of each scenario.
module tb_cpu_control_sequencer;
    logic       clk = 1'b0;
    logic       clr;
    logic       run;
    logic [3:0] ir;

    always #5 clk = ~clk;

    cpu_control_sequencer_if #(.OPW(4), .NT(7)) bus ();
    assign bus.run       = run;
    assign bus.ir_opcode = ir;

    cpu_control_sequencer #(.OPW(4), .NT(7)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // control vector bit positions
    localparam logic [10:0] M_PC_OUT = 11'h400, M_PC_INC = 11'h200, M_MAR = 11'h100,
                            M_RAM_OUT = 11'h080, M_IR_LD = 11'h040, M_IR_OUT = 11'h020,
                            M_A_LD = 11'h010, M_A_OUT = 11'h008, M_B_LD = 11'h004,
                            M_ALU_EN = 11'h002, M_OUT_LD = 11'h001;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int         m_t;
    logic [3:0] m_op;
    logic [1:0] m_sel;
    bit         m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_alu(input logic [3:0] op);
        return op >= 4'h1 && op <= 4'h4;
    endfunction

    function automatic int last_state(input logic [3:0] op);
        if (op == 4'h0) return 5;
        if (m_alu(op))  return 7;
        if (op == 4'hF) return 99;
        return 4;
    endfunction

    function automatic logic [10:0] exp_ctrl();
        logic [3:0] op;
        op = (m_t == 4) ? ir : m_op;
        if (!run || m_halt) return '0;
        case (m_t)
            1: return M_PC_OUT | M_MAR;
            2: return M_PC_INC;
            3: return M_RAM_OUT | M_IR_LD;
            4: if (op == 4'h0 || m_alu(op)) return M_IR_OUT | M_MAR;
               else if (op == 4'hE) return M_A_OUT | M_OUT_LD;
            5: if (op == 4'h0) return M_RAM_OUT | M_A_LD;
               else if (m_alu(op)) return M_RAM_OUT | M_B_LD;
            7: if (m_alu(op)) return M_ALU_EN | M_A_LD;
            default: ;
        endcase
        return '0;
    endfunction

    task automatic model_reset();
        m_t = 1; m_op = 4'h0; m_sel = 2'b00; m_halt = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] op;
        if (clr) begin
            model_reset();
        end else if (run && !m_halt) begin
            op = (m_t == 4) ? ir : m_op;
            if (m_t == 4) begin
                m_op = ir;
                if (m_alu(ir)) m_sel = 2'(ir - 4'h1);
                if (ir == 4'hF) m_halt = 1'b1;
            end
            if (EARLY && m_t == last_state(op)) m_t = 1;
            else m_t = (m_t % 7) + 1;
        end
    endtask

    task automatic check_all();
        logic [10:0] act;
        act = {bus.pc_out, bus.pc_inc, bus.mar_load, bus.ram_out, bus.ir_load, bus.ir_out,
               bus.a_load, bus.a_out, bus.b_load, bus.alu_en, bus.out_load};
        chk("tstate",  32'(bus.tstate),  32'(1 << (m_t - 1)));
        chk("ctrl",    32'(act),         32'(exp_ctrl()));
        chk("alu_sel", 32'(bus.alu_sel), 32'(m_sel));
        chk("halted",  32'(bus.halted),  32'(m_halt));
        chk("bus_onehot",
            32'($countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_en}) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to_t1(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (m_t != 1 && k < 20);
        if (m_t != 1) chk("t1_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clr = 1'b1; run = 1'b1; ir = 4'h0;
        model_reset();
        #2;
        check_all();
        chk("rst_tstate", 32'(bus.tstate), 32'h01);
        chk("rst_pc_mar", 32'({bus.pc_out, bus.mar_load}), 32'h3);
        @(negedge clk);
        clr = 1'b0;

        // LDA into T5, then clr mid-instruction
        repeat (4) tick();
        chk("lda_t5_ram_a", 32'({bus.ram_out, bus.a_load}), 32'h3);
        #2 clr = 1'b1;
        #1 model_reset();
        check_all();
        chk("clr_mid_t5_tstate", 32'(bus.tstate), 32'h01);
        chk("clr_alu_sel", 32'(bus.alu_sel), 32'h0);
        tick();
        clr = 1'b0;

        // ADD
        ir = 4'h1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 4) begin
                chk("add_t5_ram_b", 32'({bus.ram_out, bus.b_load}), 32'h3);
                chk("add_t5_sel", 32'(bus.alu_sel), 32'h0);
            end
            if (i == 6) chk("add_t7_alu_a", 32'({bus.alu_en, bus.a_load}), 32'h3);
        end
        chk("add_back_t1", 32'(bus.tstate), 32'h01);

        // DIV then OUT
        ir = 4'h4;
        repeat (4) tick();
        chk("div_t5_sel", 32'(bus.alu_sel), 32'h3);
        repeat (3) tick();
        ir = 4'hE;
        repeat (3) tick();
        chk("out_t4_aout_load", 32'({bus.a_out, bus.out_load}), 32'h3);
        chk("out_sel_held", 32'(bus.alu_sel), 32'h3);
        run_to_t1(k);

        // SUB / MUL select values
        ir = 4'h2; run_to_t1(k);
        chk("sub_sel", 32'(bus.alu_sel), 32'h1);
        ir = 4'h3; run_to_t1(k);
        chk("mul_sel", 32'(bus.alu_sel), 32'h2);

        // Stall in T3
        ir = 4'h0;
        repeat (2) tick();
        run = 1'b0;
        #1 check_all();
        chk("stall_ram_ir", 32'({bus.ram_out, bus.ir_load}), 32'h0);
        repeat (3) tick();
        chk("stall_tstate", 32'(bus.tstate), 32'h04);
        run = 1'b1;
        #1 check_all();
        chk("resume_ram_ir", 32'({bus.ram_out, bus.ir_load}), 32'h3);
        tick();
        chk("resume_t4", 32'(bus.tstate), 32'h08);
        run_to_t1(k);

        // Instruction lengths
        ir = 4'h0; run_to_t1(k);
        chk("lda_len", 32'(k), EARLY ? 32'd5 : 32'd7);
        ir = 4'h5; run_to_t1(k);
        chk("nop_len", 32'(k), EARLY ? 32'd4 : 32'd7);

        // HLT, freeze, recover
        ir = 4'hF;
        repeat (4) tick();
        chk("hlt_halted", 32'(bus.halted), 32'h1);
        chk("hlt_t5", 32'(bus.tstate), 32'h10);
        repeat (20) tick();
        chk("hlt_frozen", 32'(bus.tstate), 32'h10);
        clr = 1'b1;
        #1 model_reset();
        check_all();
        chk("hlt_clr_t1", 32'(bus.tstate), 32'h01);
        tick();
        clr = 1'b0;
        ir = 4'h0;
        tick();
        chk("hlt_clr_t2", 32'(bus.tstate), 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
